// File: rtl/max7219_frame_loader_if.sv
// UART-byte input, SPI-master handshake and status outputs of the MAX7219 frame loader.
interface max7219_frame_loader_if;
    logic        i_rx_stb;
    logic [7:0]  i_rx_data;
    logic        i_spi_busy;
    logic        o_spi_wr;
    logic [15:0] o_spi_data;
    logic        o_init_done;
    logic        o_frame_done;
    logic        o_err;

    modport slave (
        input  i_rx_stb, i_rx_data, i_spi_busy,
        output o_spi_wr, o_spi_data, o_init_done, o_frame_done, o_err
    );

    modport master (
        output i_rx_stb, i_rx_data, i_spi_busy,
        input  o_spi_wr, o_spi_data, o_init_done, o_frame_done, o_err
    );
endinterface

// File: rtl/max7219_frame_loader.sv
// Parses '<' + 8 row bytes + '>' UART frames and streams MAX7219 register writes
// (power-up init, then one 8-row refresh per accepted frame) through a 16-bit SPI master.
module max7219_frame_loader #(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7,
    parameter logic [7:0] SOF_BYTE   = 8'h3C,
    parameter logic [7:0] EOF_BYTE   = 8'h3E
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    max7219_frame_loader_if.slave bus
);
    localparam int unsigned ROWS  = 8;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 3;

    // Word index: 0..4 are control registers, 5..12 are digit rows 0..7.
    localparam logic [IDX_W-1:0] FIRST_ROW_IDX = IDX_W'(5);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(12);

    typedef enum logic [1:0] {P_IDLE, P_DATA, P_END} p_state_e;
    typedef enum logic [2:0] {W_INIT, W_IDLE, W_SEND, W_SETTLE, W_WAIT} w_state_e;

    p_state_e         p_q, p_d;
    w_state_e         w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [7:0]       rx_buf_q [ROWS];
    logic [7:0]       rx_buf_d [ROWS];
    logic [7:0]       disp_q   [ROWS];
    logic [7:0]       disp_d   [ROWS];

    logic             wr_q, wr_d;
    logic [15:0]      data_q, data_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic [15:0]      word_c;
    logic             sending_c;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p_q          <= P_IDLE;
            w_q          <= W_INIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            rx_buf_q     <= '{default: '0};
            disp_q       <= '{default: '0};
            wr_q         <= 1'b0;
            data_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            p_q          <= p_d;
            w_q          <= w_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            rx_buf_q     <= rx_buf_d;
            disp_q       <= disp_d;
            wr_q         <= wr_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Register word addressed by the current index
    always_comb begin
        word_c = '0;
        case (idx_q)
            IDX_W'(0): word_c = 16'h0F00;
            IDX_W'(1): word_c = 16'h0900;
            IDX_W'(2): word_c = {8'h0A, 4'h0, INTENSITY};
            IDX_W'(3): word_c = {8'h0B, 5'h0, SCAN_LIMIT};
            IDX_W'(4): word_c = 16'h0C01;
            default:   word_c = {8'(idx_q) - 8'd4, disp_q[CNT_W'(idx_q - FIRST_ROW_IDX)]};
        endcase
    end

    assign sending_c = (w_q == W_INIT || w_q == W_SEND) && !bus.i_spi_busy;

    // Next-state logic for parser and writer
    always_comb begin
        p_d      = p_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        rx_buf_d = rx_buf_q;
        disp_d   = disp_q;

        if (bus.i_rx_stb) begin
            case (p_q)
                P_IDLE: begin
                    if (bus.i_rx_data == SOF_BYTE && !pend_q) begin
                        p_d   = P_DATA;
                        cnt_d = '0;
                    end
                end
                P_DATA: begin
                    rx_buf_d[cnt_q] = bus.i_rx_data;
                    cnt_d           = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ROWS - 1)) p_d = P_END;
                end
                P_END: begin
                    p_d = P_IDLE;
                    if (bus.i_rx_data == EOF_BYTE) pend_d = 1'b1;
                end
                default: p_d = P_IDLE;
            endcase
        end

        // pend is only set by the parser while it is clear, so the writer's clear never collides
        case (w_q)
            W_INIT, W_SEND: if (!bus.i_spi_busy) w_d = W_SETTLE;
            W_SETTLE:       w_d = W_WAIT;
            W_WAIT: begin
                if (!bus.i_spi_busy) begin
                    if (idx_q == LAST_IDX) begin
                        w_d = W_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        w_d   = init_done_q ? W_SEND : W_INIT;
                    end
                end
            end
            W_IDLE: begin
                if (pend_q) begin
                    disp_d = rx_buf_q;
                    pend_d = 1'b0;
                    idx_d  = FIRST_ROW_IDX;
                    w_d    = W_SEND;
                end
            end
            default: w_d = W_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        wr_d         = 1'b0;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        if (bus.i_rx_stb) begin
            if (p_q == P_IDLE && pend_q && bus.i_rx_data == SOF_BYTE) err_d = 1'b1;
            if (p_q == P_END && bus.i_rx_data != EOF_BYTE)            err_d = 1'b1;
        end

        if (sending_c) begin
            wr_d   = 1'b1;
            data_d = word_c;
        end

        if (w_q == W_WAIT && !bus.i_spi_busy && idx_q == LAST_IDX) begin
            if (init_done_q) frame_done_d = 1'b1;
            else             init_done_d  = 1'b1;
        end
    end

    assign bus.o_spi_wr     = wr_q;
    assign bus.o_spi_data   = data_q;
    assign bus.o_init_done  = init_done_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_max7219_frame_loader.sv
// Scoreboard bench for max7219_frame_loader: a busy-modelling SPI responder pops expected words on every wr.
module tb_max7219_frame_loader;
    localparam logic [3:0] INTENSITY  = 4'h8;
    localparam logic [2:0] SCAN_LIMIT = 3'd7;
    localparam logic [7:0] SOF        = 8'h3C;
    localparam logic [7:0] EOF        = 8'h3E;

    typedef struct packed {
        logic [15:0] word;
        logic [1:0]  kind;   // 0 plain, 1 last row of a refresh, 2 last init word
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max7219_frame_loader_if bus ();

    max7219_frame_loader #(
        .INTENSITY (INTENSITY),
        .SCAN_LIMIT(SCAN_LIMIT),
        .SOF_BYTE  (SOF),
        .EOF_BYTE  (EOF)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    exp_t    exp_q[$];
    int      checks = 0;
    int      failures = 0;
    int      lat = 32;
    int      wr_count = 0;
    int      wr_since_rst = 0;
    int      fd_count = 0;
    int      err_count = 0;
    int      err_exp = 0;
    int      fd_exp = 0;
    logic [1:0] last_kind = 2'd0;
    longint  cyc = 0;
    longint  last_wr_cyc = -10;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: the power-up register sequence followed by a blank 8-row refresh
    function automatic void push_init();
        exp_q.push_back({16'h0F00, 2'd0});
        exp_q.push_back({16'h0900, 2'd0});
        exp_q.push_back({8'h0A, 4'h0, INTENSITY, 2'd0});
        exp_q.push_back({8'h0B, 5'h0, SCAN_LIMIT, 2'd0});
        exp_q.push_back({16'h0C01, 2'd0});
        for (int r = 0; r < 8; r++)
            exp_q.push_back({8'(r + 1), 8'h00, (r == 7) ? 2'd2 : 2'd0});
    endfunction

    function automatic void push_frame(input logic [7:0] rows [8]);
        for (int r = 0; r < 8; r++)
            exp_q.push_back({8'(r + 1), rows[r], (r == 7) ? 2'd1 : 2'd0});
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_stb  = 1'b1;
        bus.i_rx_data = b;
        @(negedge clk);
        bus.i_rx_stb  = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] rows [8], input logic [7:0] last_b);
        send_byte(SOF);
        for (int r = 0; r < 8; r++) send_byte(rows[r]);
        send_byte(last_b);
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int n = 0;
        while (fd_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(fd_count), 32'(target));
    endtask

    task automatic wait_init(input int budget, input string name);
        int n = 0;
        while (bus.o_init_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.o_init_done), 32'd1);
    endtask

    // SPI responder and output monitor
    initial begin
        exp_t e;
        int   bleft = 0;
        logic prev_init = 1'b0;
        bus.i_spi_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                bleft          = 0;
                bus.i_spi_busy = 1'b0;
                prev_init      = 1'b0;
                wr_since_rst   = 0;
            end else begin
                if (bus.o_spi_wr) begin
                    check("wr_while_busy", 32'(bus.i_spi_busy), 32'd0);
                    check("wr_spacing", 32'(cyc - last_wr_cyc > 2), 32'd1);
                    last_wr_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_wr actual=%0h required=none", bus.o_spi_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("spi_word", 32'(bus.o_spi_data), 32'(e.word));
                        last_kind = e.kind;
                    end
                    wr_count++;
                    wr_since_rst++;
                    bleft = lat;
                end else begin
                    bus.i_spi_busy = (bleft > 0);
                    if (bleft > 0) bleft--;
                end
                if (bus.o_frame_done) begin
                    fd_count++;
                    check("frame_done_after_last_row", 32'(last_kind), 32'd1);
                end
                if (bus.o_err) err_count++;
                if (bus.o_init_done && !prev_init) begin
                    check("init_done_after_last_init_word", 32'(last_kind), 32'd2);
                    check("init_word_count", 32'(wr_since_rst), 32'd13);
                end
                if (prev_init) check("init_done_sticky", 32'(bus.o_init_done), 32'd1);
                prev_init = bus.o_init_done;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rows [8];
        logic [7:0] rows_b [8];
        logic [7:0] b;
        int         n;

        bus.i_rx_stb  = 1'b0;
        bus.i_rx_data = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(bus.o_spi_wr), 32'd0);
        check("rst_data", 32'(bus.o_spi_data), 32'd0);
        check("rst_init_done", 32'(bus.o_init_done), 32'd0);
        check("rst_frame_done", 32'(bus.o_frame_done), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);

        // Power-up init with a slow SPI master
        lat = 32;
        push_init();
        rst_n = 1'b1;
        wait_init(2000, "init_done_rise");
        check("init_words_consumed", 32'(exp_q.size()), 32'd0);

        // Ramp frame
        for (int r = 0; r < 8; r++) rows[r] = 8'(r + 1);
        push_frame(rows);
        send_frame(rows, EOF);
        fd_exp++;
        wait_fd(fd_exp, 2000, "ramp_frame_done");

        // Bad terminator: error pulse, no writes, parser recovers
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        send_frame(rows, 8'h58);
        err_exp++;
        repeat (40) @(negedge clk);
        check("bad_frame_err", 32'(err_count), 32'(err_exp));
        check("bad_frame_no_wr", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        push_frame(rows);
        send_frame(rows, EOF);
        fd_exp++;
        wait_fd(fd_exp, 2000, "recover_frame_done");

        // SOF/EOF values inside the payload are plain row data
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        rows[0] = SOF;
        rows[1] = EOF;
        push_frame(rows);
        send_frame(rows, EOF);
        fd_exp++;
        wait_fd(fd_exp, 2000, "delim_data_frame_done");

        // Second frame lands during a refresh; a further SOF while it is pending is dropped
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        for (int r = 0; r < 8; r++) rows_b[r] = 8'($urandom);
        push_frame(rows);
        n = wr_count;
        send_frame(rows, EOF);
        while (wr_count == n) @(negedge clk);
        push_frame(rows_b);
        send_frame(rows_b, EOF);
        send_byte(SOF);
        err_exp++;
        fd_exp += 2;
        wait_fd(fd_exp, 4000, "pending_frames_done");
        check("pending_sof_err", 32'(err_count), 32'(err_exp));

        // Randomized frames, latencies, garbage and bad terminators
        for (int it = 0; it < 12; it++) begin
            lat = $urandom_range(2, 40);
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SOF) b = 8'h00;
                send_byte(b);
            end
            for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                if (b == EOF) b = 8'h41;
                send_frame(rows, b);
                err_exp++;
            end else begin
                push_frame(rows);
                send_frame(rows, EOF);
                fd_exp++;
                wait_fd(fd_exp, 2000, "rand_frame_done");
            end
        end
        check("rand_err_count", 32'(err_count), 32'(err_exp));

        // Reset during the third row word aborts; init reruns and a mid-init frame follows it
        lat = 32;
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        push_frame(rows);
        n = wr_count;
        send_frame(rows, EOF);
        begin
            int k = 0;
            while (wr_count < n + 3 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            check("third_row_reached", 32'(wr_count >= n + 3), 32'd1);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_wr", 32'(bus.o_spi_wr), 32'd0);
        check("abort_data", 32'(bus.o_spi_data), 32'd0);
        check("abort_init_done", 32'(bus.o_init_done), 32'd0);
        check("abort_frame_done", 32'(bus.o_frame_done), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        n = fd_count;
        push_init();
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
        push_frame(rows);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(rows, EOF);
        wait_init(2000, "reinit_done_rise");
        check("no_frame_done_during_init", 32'(fd_count), 32'(n));
        fd_exp = n + 1;
        wait_fd(fd_exp, 2000, "mid_init_frame_done");

        repeat (20) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_err_count", 32'(err_count), 32'(err_exp));
        check("final_frame_done_count", 32'(fd_count), 32'(fd_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
